// File: rtl/stream_join_sched.sv
// stream_join_sched: select-mask FIFO plus N-way join sequencer.
// Each queued mask names the inputs that must all be valid before one
// joined output beat is produced. An all-zero mask is discarded in one
// cycle and reported with a zero_drop_o pulse.
module stream_join_sched #(
  parameter  int N_INP = 2,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  input  logic [N_INP-1:0] sel_i,
  input  logic [N_INP-1:0] inp_valid_i,
  output logic [N_INP-1:0] inp_ready_o,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output logic [N_INP-1:0] oup_sel_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             zero_drop_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [N_INP-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             head_valid;
  logic [N_INP-1:0] head;
  logic             head_zero;
  logic             join_ok;
  logic             beat;
  logic             push;
  logic             pop;

  // Head decode, join evaluation and handshake generation
  always_comb begin
    head_valid  = (count != '0);
    head        = mem[rd_ptr];
    head_zero   = (head == '0);
    join_ok     = &(inp_valid_i | ~head);
    sel_ready_o = (count < CNT_W'(DEPTH));
    oup_sel_o   = head_valid ? head : '0;
    oup_valid_o = head_valid & ~head_zero & join_ok & ~flush_i;
    beat        = oup_valid_o & oup_ready_i;
    inp_ready_o = head & {N_INP{beat}};
    zero_drop_o = head_valid & head_zero & ~flush_i;
    pop         = beat | zero_drop_o;
    push        = sel_valid_i & sel_ready_o;
    usage_o     = count;
  end

  // Mask storage; contents need no reset since count guards every read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= sel_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides push and pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_join_sched.sv
// Testbench for stream_join_sched: scoreboard of pushed masks compared
// against the joined beats and zero-mask drops the design produces.
module tb_stream_join_sched;

  localparam int N_INP = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             sel_valid_i;
  logic             sel_ready_o;
  logic [N_INP-1:0] sel_i;
  logic [N_INP-1:0] inp_valid_i;
  logic [N_INP-1:0] inp_ready_o;
  logic             oup_valid_o;
  logic             oup_ready_i;
  logic [N_INP-1:0] oup_sel_o;
  logic [CNT_W-1:0] usage_o;
  logic             zero_drop_o;

  int vectors     = 0;
  int miscompares = 0;
  int beats       = 0;
  int drops       = 0;
  logic [N_INP-1:0] exp_q [$];

  stream_join_sched #(.N_INP(N_INP), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .sel_valid_i (sel_valid_i),
    .sel_ready_o (sel_ready_o),
    .sel_i       (sel_i),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_sel_o   (oup_sel_o),
    .usage_o     (usage_o),
    .zero_drop_o (zero_drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, then returns just after the next rising edge
  task automatic applyStimulus(input logic sv, input logic [N_INP-1:0] sel,
                               input logic [N_INP-1:0] iv, input logic ordy,
                               input logic fl);
    sel_valid_i = sv;
    sel_i       = sel;
    inp_valid_i = iv;
    oup_ready_i = ordy;
    flush_i     = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sel_ready"}, sel_ready_o, 1);
    checkOutput({tag, "_oup_valid"}, oup_valid_o, 0);
    checkOutput({tag, "_inp_ready"}, inp_ready_o, 0);
    checkOutput({tag, "_oup_sel"},   oup_sel_o,   0);
    checkOutput({tag, "_usage"},     usage_o,     0);
    checkOutput({tag, "_zero_drop"}, zero_drop_o, 0);
  endtask

  // Reference model sampled mid-cycle: checks every output, then retires
  // scoreboard entries on the beats and drops the design actually produced
  always @(negedge clk_i) begin
    int sz;
    logic [N_INP-1:0] front;
    logic [N_INP-1:0] got;
    logic exp_valid;
    logic exp_drop;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      sz        = exp_q.size();
      front     = (sz > 0) ? exp_q[0] : '0;
      exp_valid = (sz > 0) && (front != '0) && !flush_i && ((inp_valid_i | ~front) == '1);
      exp_drop  = (sz > 0) && (front == '0) && !flush_i;
      checkOutput("usage",     usage_o,     sz);
      checkOutput("sel_ready", sel_ready_o, (sz < DEPTH));
      checkOutput("oup_sel",   oup_sel_o,   front);
      checkOutput("oup_valid", oup_valid_o, exp_valid);
      checkOutput("inp_ready", inp_ready_o, (exp_valid && oup_ready_i) ? front : '0);
      checkOutput("zero_drop", zero_drop_o, exp_drop);
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (oup_valid_o && oup_ready_i) begin
          got = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          checkOutput("beat_mask", oup_sel_o, got);
          beats++;
        end else if (zero_drop_o) begin
          got = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          checkOutput("drop_mask", oup_sel_o, got);
          drops++;
        end
        if (sel_valid_i && sz < DEPTH) begin
          exp_q.push_back(sel_i);
        end
      end
    end
  end

  initial begin
    int b0;
    int d0;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    sel_valid_i = 1'b0;
    sel_i       = '0;
    inp_valid_i = '0;
    oup_ready_i = 1'b0;
    #2;
    checkReset("por");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    $display("[TB] basic join");
    b0 = beats;
    applyStimulus(1, 2'b11, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 2'b01, 1, 0);
    applyStimulus(0, 2'b00, 2'b11, 1, 0);
    applyStimulus(0, 2'b00, 2'b00, 1, 0);
    checkOutput("basic_beats", beats - b0, 1);

    $display("[TB] partial mask");
    b0 = beats;
    applyStimulus(1, 2'b10, 2'b00, 0, 0);
    applyStimulus(0, 2'b00, 2'b11, 1, 0);
    applyStimulus(0, 2'b00, 2'b00, 1, 0);
    checkOutput("partial_beats", beats - b0, 1);

    $display("[TB] full and backpressure");
    b0 = beats;
    applyStimulus(1, 2'b01, 2'b11, 0, 0);
    applyStimulus(1, 2'b10, 2'b11, 0, 0);
    applyStimulus(1, 2'b11, 2'b11, 0, 0);
    applyStimulus(1, 2'b01, 2'b11, 0, 0);
    applyStimulus(1, 2'b10, 2'b11, 0, 0);
    checkOutput("full_usage", usage_o, 4);
    checkOutput("full_ready", sel_ready_o, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b11, 1, 0);
    checkOutput("drain_beats", beats - b0, 4);
    applyStimulus(0, 2'b00, 2'b00, 1, 0);

    $display("[TB] zero-mask skip");
    b0 = beats;
    d0 = drops;
    applyStimulus(1, 2'b00, 2'b01, 1, 0);
    applyStimulus(1, 2'b01, 2'b01, 1, 0);
    applyStimulus(0, 2'b00, 2'b01, 1, 0);
    applyStimulus(0, 2'b00, 2'b00, 1, 0);
    checkOutput("zero_drops", drops - d0, 1);
    checkOutput("zero_beats", beats - b0, 1);

    $display("[TB] flush");
    b0 = beats;
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b11, 2'b11, 0, 0);
    applyStimulus(1, 2'b01, 2'b11, 1, 1);
    applyStimulus(0, 2'b00, 2'b11, 1, 0);
    checkOutput("flush_beats", beats - b0, 0);

    $display("[TB] async reset");
    b0 = beats;
    applyStimulus(1, 2'b11, 2'b01, 1, 0);
    applyStimulus(1, 2'b10, 2'b01, 1, 0);
    checkOutput("pre_reset_usage", usage_o, 2);
    #2;
    rst_i = 1'b1;
    #1;
    checkReset("async");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(0, 2'b00, 2'b11, 1, 0);
    checkOutput("post_reset_usage", usage_o, 0);
    applyStimulus(1, 2'b01, 2'b11, 1, 0);
    applyStimulus(0, 2'b00, 2'b11, 1, 0);
    applyStimulus(0, 2'b00, 2'b00, 1, 0);
    checkOutput("reset_beats", beats - b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
